llr_plane_packer: RTL and testbench

- Upstream feeder for the turbo decoder core.
- Accepts one trellis step per handshake from the demapper: a 4-bit signed LLR triplet of systematic, parity-1 and parity-2.
- Buffers a full block of STEPS steps (5 info + 2 tail) in a ping-pong store.
- Emits the block as NUM_PLANES consecutive 21-bit bit-plane words, LSB plane first, with start asserted. Holds the next block until the decoder signals done.

---
 rtl/turbo_pkg.sv | 33 +++
 rtl/llr_plane_packer_if.sv | 14 +
 rtl/llr_bank.sv | 31 +++
 rtl/llr_plane_packer.sv | 121 ++++++++++++
 tb/tb_llr_plane_packer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
// Shared constants, types and FSM encoding for the LLR bit-plane packer.
// The LLR_SYM_CLIP_EN build option uses llr_clip() to map the most negative LLR onto its symmetric value.
package turbo_pkg;

  localparam int STEPS      = 7;
  localparam int LLR_W      = 4;
  localparam int NUM_PLANES = 4;
  localparam int WORD_W     = 3 * STEPS;
  localparam int IDX_W      = $clog2(STEPS);
  localparam int PL_W       = $clog2(NUM_PLANES);

  typedef logic [LLR_W-1:0] llr_t;

  localparam llr_t LLR_MIN  = {1'b1, {(LLR_W-1){1'b0}}};
  localparam llr_t LLR_CLIP = {1'b1, {(LLR_W-2){1'b0}}, 1'b1};

  typedef struct packed {
    llr_t sys;
    llr_t par1;
    llr_t par2;
  } llr_triplet_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE
  } send_state_t;

  function automatic llr_t llr_clip(input llr_t v);
    return (v == LLR_MIN) ? LLR_CLIP : v;
  endfunction

endpackage

// File: rtl/llr_plane_packer_if.sv
// Demapper-to-packer step handshake: one systematic/parity-1/parity-2 LLR triplet per transfer.
interface llr_plane_packer_if;
  import turbo_pkg::*;

  logic sym_valid;
  logic sym_ready;
  llr_t sym_sys;
  llr_t sym_par1;
  llr_t sym_par2;

  modport master (output sym_valid, sym_sys, sym_par1, sym_par2, input sym_ready);
  modport slave  (input sym_valid, sym_sys, sym_par1, sym_par2, output sym_ready);

endinterface

// File: rtl/llr_bank.sv
// One block of STEPS LLR triplets: indexed write port, bit-plane read port.
module llr_bank
  import turbo_pkg::*;
(
  input  logic              clk_p_i,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  llr_triplet_t      wr_data,
  input  logic [PL_W-1:0]   rd_pl,
  output logic [WORD_W-1:0] rd_word
);

  llr_triplet_t mem [STEPS];

  // NOTE: storage has no reset; validity is tracked by the owner's full flag,
  // and non-blocking assignment keeps the write ordered against same-edge reads.
  always_ff @(posedge clk_p_i) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    rd_word = '0;
    for (int j = 0; j < STEPS; j++) begin
      rd_word[2*STEPS + j] = mem[j].sys[rd_pl];
      rd_word[STEPS + j]   = mem[j].par1[rd_pl];
      rd_word[j]           = mem[j].par2[rd_pl];
    end
  end

endmodule

// File: rtl/llr_plane_packer.sv
// Ping-pong LLR block buffer feeding the turbo decoder as LSB-first bit-plane words.
// Define LLR_SYM_CLIP_EN to store the most negative LLR as its symmetric counterpart.
module llr_plane_packer
  import turbo_pkg::*;
(
  input  logic                clk_p_i,
  input  logic                reset_p_i,
  llr_plane_packer_if.slave   sym,
  output logic [WORD_W-1:0]   data_o,
  output logic                start_o,
  input  logic                dec_done_i,
  output logic [7:0]          blk_cnt_o
);

  logic [1:0]        full;
  logic              fill_bank;
  logic              send_bank;
  logic [IDX_W-1:0]  step_cnt;
  send_state_t       state;
  logic [PL_W-1:0]   pl;
  logic              dec_done_q;

  logic              xfer;
  logic              fill_last;
  logic              release_bank;
  llr_triplet_t      wr_data;
  logic [PL_W-1:0]   rd_pl;
  logic [WORD_W-1:0] bank_word [2];
  logic [WORD_W-1:0] send_word;

  assign sym.sym_ready = !full[fill_bank];
  assign xfer          = sym.sym_valid && sym.sym_ready;
  assign fill_last     = xfer && (step_cnt == IDX_W'(STEPS - 1));
  assign release_bank  = (state == ST_WAIT_DONE) && dec_done_i && !dec_done_q;

  always_comb begin
`ifdef LLR_SYM_CLIP_EN
    wr_data = '{sys: llr_clip(sym.sym_sys), par1: llr_clip(sym.sym_par1), par2: llr_clip(sym.sym_par2)};
`else
    wr_data = '{sys: sym.sym_sys, par1: sym.sym_par1, par2: sym.sym_par2};
`endif
  end

  // Read one plane ahead so the registered data_o shows plane pl while in SEND.
  assign rd_pl     = (state == ST_SEND) ? pl + 1'b1 : '0;
  assign send_word = bank_word[send_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    llr_bank u_bank (
      .clk_p_i (clk_p_i),
      .wr_en   (xfer && (fill_bank == 1'(b))),
      .wr_idx  (step_cnt),
      .wr_data (wr_data),
      .rd_pl   (rd_pl),
      .rd_word (bank_word[b])
    );
  end

  // Fill and release never target the same bank: a full bank is never being filled.
  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      full      <= '0;
      fill_bank <= 1'b0;
      step_cnt  <= '0;
    end else begin
      if (xfer) begin
        if (fill_last) begin
          full[fill_bank] <= 1'b1;
          fill_bank       <= ~fill_bank;
          step_cnt        <= '0;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
      if (release_bank) full[send_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      state      <= ST_IDLE;
      pl         <= '0;
      send_bank  <= 1'b0;
      start_o    <= 1'b0;
      data_o     <= '0;
      blk_cnt_o  <= '0;
      dec_done_q <= 1'b0;
    end else begin
      dec_done_q <= dec_done_i;
      case (state)
        ST_IDLE: begin
          if (full[send_bank]) begin
            state   <= ST_SEND;
            pl      <= '0;
            start_o <= 1'b1;
            data_o  <= send_word;
          end
        end
        ST_SEND: begin
          if (pl == PL_W'(NUM_PLANES - 1)) begin
            state   <= ST_WAIT_DONE;
            start_o <= 1'b0;
            data_o  <= '0;
          end else begin
            pl     <= pl + 1'b1;
            data_o <= send_word;
          end
        end
        ST_WAIT_DONE: begin
          if (release_bank) begin
            send_bank <= ~send_bank;
            blk_cnt_o <= blk_cnt_o + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llr_plane_packer.sv
// Directed bench for llr_plane_packer: latency, back-pressure, done-edge release, reset and clipping.
`timescale 1ns/1ps
module tb_llr_plane_packer;
  import turbo_pkg::*;

  logic              clk_p_i = 1'b0;
  logic              reset_p_i;
  logic [WORD_W-1:0] data_o;
  logic              start_o;
  logic              dec_done_i;
  logic [7:0]        blk_cnt_o;

  llr_plane_packer_if sif ();

  llr_plane_packer dut (
    .clk_p_i    (clk_p_i),
    .reset_p_i  (reset_p_i),
    .sym        (sif),
    .data_o     (data_o),
    .start_o    (start_o),
    .dec_done_i (dec_done_i),
    .blk_cnt_o  (blk_cnt_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [WORD_W-1:0] seen_q [$];
  logic [WORD_W-1:0] exp_q  [$];

  // Capture every plane word just after the edge that produces it.
  always @(posedge clk_p_i) begin
    #1;
    if (start_o) seen_q.push_back(data_o);
  end

  llr_t bs  [STEPS];
  llr_t bp1 [STEPS];
  llr_t bp2 [STEPS];

  function automatic llr_t tb_clip(input llr_t v);
`ifdef LLR_SYM_CLIP_EN
    return (v == 4'h8) ? 4'h9 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [WORD_W-1:0] model_plane(input int p);
    logic [WORD_W-1:0] w;
    llr_t s, a, b;
    w = '0;
    for (int j = 0; j < STEPS; j++) begin
      s = tb_clip(bs[j]);
      a = tb_clip(bp1[j]);
      b = tb_clip(bp2[j]);
      w[2*STEPS + j] = s[p];
      w[STEPS + j]   = a[p];
      w[j]           = b[p];
    end
    return w;
  endfunction

  task automatic make_block(input int seed, input bit expect_it);
    for (int j = 0; j < STEPS; j++) begin
      bs[j]  = llr_t'(seed * 5 + j * 3);
      bp1[j] = llr_t'(seed + j * 7 + 1);
      bp2[j] = llr_t'(seed * 3 + j * 11 + 2);
    end
    if (expect_it)
      for (int p = 0; p < NUM_PLANES; p++) exp_q.push_back(model_plane(p));
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic push_step(input llr_t s, input llr_t a, input llr_t b);
    int waited;
    waited = 0;
    sif.sym_valid = 1'b1;
    sif.sym_sys   = s;
    sif.sym_par1  = a;
    sif.sym_par2  = b;
    while (!sif.sym_ready && waited < 200) begin
      @(negedge clk_p_i);
      waited++;
    end
    check("push_ready", {31'b0, sif.sym_ready}, 32'd1);
    @(negedge clk_p_i);
    sif.sym_valid = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int j = lo; j < hi; j++) push_step(bs[j], bp1[j], bp2[j]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_p_i);
  endtask

  task automatic pulse_done();
    dec_done_i = 1'b1;
    @(negedge clk_p_i);
    dec_done_i = 1'b0;
    @(negedge clk_p_i);
  endtask

  task automatic compare_seen(input string tag);
    check({tag, "_count"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), {11'b0, seen_q[i]}, {11'b0, exp_q[i]});
    seen_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [WORD_W-1:0] exp_a [NUM_PLANES];
  logic [WORD_W-1:0] exp_p2;
  logic [WORD_W-1:0] w0, w3;

  initial begin
    // sys=0101, par1=1010, par2=0011 at every step
    exp_a = '{21'h1FC07F, 21'h003FFF, 21'h1FC000, 21'h003F80};
    reset_p_i     = 1'b1;
    dec_done_i    = 1'b0;
    sif.sym_valid = 1'b0;
    sif.sym_sys   = '0;
    sif.sym_par1  = '0;
    sif.sym_par2  = '0;
    cycles(3);
    reset_p_i = 1'b0;
    @(negedge clk_p_i);
    check("rst_ready", {31'b0, sif.sym_ready}, 32'd1);
    check("rst_start", {31'b0, start_o}, 32'd0);
    check("rst_data",  {11'b0, data_o}, 32'd0);
    check("rst_blk",   {24'b0, blk_cnt_o}, 32'd0);

    // Single block: latency, exact plane words, blk_cnt waits for done edge.
    for (int j = 0; j < STEPS; j++) push_step(4'h5, 4'hA, 4'h3);
    check("a_lat_idle", {31'b0, start_o}, 32'd0);
    for (int p = 0; p < NUM_PLANES; p++) begin
      @(negedge clk_p_i);
      check($sformatf("a_start%0d", p), {31'b0, start_o}, 32'd1);
      check($sformatf("a_plane%0d", p), {11'b0, data_o}, {11'b0, exp_a[p]});
    end
    @(negedge clk_p_i);
    check("a_start_end", {31'b0, start_o}, 32'd0);
    check("a_data_end",  {11'b0, data_o}, 32'd0);
    cycles(3);
    check("a_blk_hold", {24'b0, blk_cnt_o}, 32'd0);
    dec_done_i = 1'b1;
    @(negedge clk_p_i);
    check("a_blk_rel", {24'b0, blk_cnt_o}, 32'd1);
    dec_done_i = 1'b0;
    @(negedge clk_p_i);
    seen_q.delete();

    // Back-pressure: two blocks fill both banks, step 15 stalls until release.
    make_block(1, 1'b1);
    push_range(0, 7);
    make_block(2, 1'b1);
    push_range(0, 7);
    check("b_ready_low", {31'b0, sif.sym_ready}, 32'd0);
    make_block(3, 1'b1);
    sif.sym_valid = 1'b1;
    sif.sym_sys   = bs[0];
    sif.sym_par1  = bp1[0];
    sif.sym_par2  = bp2[0];
    cycles(4);
    check("b_stall", {31'b0, sif.sym_ready}, 32'd0);
    dec_done_i = 1'b1;
    @(negedge clk_p_i);
    check("b_ready_rel", {31'b0, sif.sym_ready}, 32'd1);
    dec_done_i = 1'b0;
    @(negedge clk_p_i);
    sif.sym_valid = 1'b0;
    push_range(1, 6);
    cycles(8);

    // Release of block 2 and completion of block 3 on the same edge.
    sif.sym_valid = 1'b1;
    sif.sym_sys   = bs[6];
    sif.sym_par1  = bp1[6];
    sif.sym_par2  = bp2[6];
    dec_done_i    = 1'b1;
    @(negedge clk_p_i);
    sif.sym_valid = 1'b0;
    dec_done_i    = 1'b0;
    check("sim_ready", {31'b0, sif.sym_ready}, 32'd1);
    check("sim_blk",   {24'b0, blk_cnt_o}, 32'd3);
    make_block(4, 1'b1);
    push_range(0, 7);
    check("sim_ready_low", {31'b0, sif.sym_ready}, 32'd0);
    cycles(2);
    pulse_done();
    cycles(8);
    pulse_done();
    cycles(2);
    check("sim_blk_end", {24'b0, blk_cnt_o}, 32'd5);
    compare_seen("order");

    // A done level held high does not release the following block.
    make_block(5, 1'b1);
    push_range(0, 7);
    cycles(7);
    dec_done_i = 1'b1;
    @(negedge clk_p_i);
    check("hold_first", {24'b0, blk_cnt_o}, 32'd6);
    make_block(6, 1'b1);
    push_range(0, 7);
    cycles(10);
    check("hold_no_rel", {24'b0, blk_cnt_o}, 32'd6);
    dec_done_i = 1'b0;
    @(negedge clk_p_i);
    dec_done_i = 1'b1;
    @(negedge clk_p_i);
    check("hold_rel", {24'b0, blk_cnt_o}, 32'd7);
    dec_done_i = 1'b0;
    @(negedge clk_p_i);
    compare_seen("hold");

    // Reset during plane 2 with a partial block pending.
    make_block(7, 1'b0);
    exp_p2 = model_plane(2);
    push_range(0, 7);
    push_step(4'h1, 4'h2, 4'h3);
    push_step(4'h4, 4'h5, 4'h6);
    @(negedge clk_p_i);
    check("rst_pre_start", {31'b0, start_o}, 32'd1);
    check("rst_pre_plane2", {11'b0, data_o}, {11'b0, exp_p2});
    reset_p_i = 1'b1;
    @(negedge clk_p_i);
    check("mid_rst_start", {31'b0, start_o}, 32'd0);
    check("mid_rst_data",  {11'b0, data_o}, 32'd0);
    check("mid_rst_ready", {31'b0, sif.sym_ready}, 32'd1);
    check("mid_rst_blk",   {24'b0, blk_cnt_o}, 32'd0);
    reset_p_i = 1'b0;
    seen_q.delete();
    exp_q.delete();
    cycles(8);
    check("rst_no_residual", seen_q.size(), 32'd0);
    make_block(8, 1'b1);
    push_range(0, 7);
    cycles(7);
    compare_seen("post_rst");
    pulse_done();
    check("post_rst_blk", {24'b0, blk_cnt_o}, 32'd1);

    // Most negative systematic LLR at every step.
    for (int j = 0; j < STEPS; j++) begin
      bs[j]  = 4'h8;
      bp1[j] = llr_t'(j);
      bp2[j] = llr_t'(15 - j);
    end
    for (int p = 0; p < NUM_PLANES; p++) exp_q.push_back(model_plane(p));
    push_range(0, 7);
    cycles(7);
    check("clip_count", seen_q.size(), 32'd4);
    if (seen_q.size() >= 4) begin
      w0 = seen_q[0];
      w3 = seen_q[3];
`ifdef LLR_SYM_CLIP_EN
      check("clip_pl0_sys", {25'b0, w0[20:14]}, 32'h7F);
`else
      check("clip_pl0_sys", {25'b0, w0[20:14]}, 32'h00);
`endif
      check("clip_pl3_sys", {25'b0, w3[20:14]}, 32'h7F);
    end
    compare_seen("clip");
    pulse_done();
    check("clip_blk", {24'b0, blk_cnt_o}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
